// File: rtl/oflow_dma_set_feeder.sv
// DMA-side feeder: reads a frame's bboxes from frame memory, packs them into PE-wide sets,
// hands each set to the core and captures the returned ID vector at frame end.
module oflow_dma_set_feeder #(
  parameter int unsigned PeNum     = 24,
  parameter int unsigned BboxW     = 128,
  parameter int unsigned MaxBboxes = 48,
  parameter int unsigned IdLen     = 12,
  parameter int unsigned AddrW     = 6,
  parameter int unsigned CntW      = 7
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_frame_i,
  input  logic [CntW-1:0]            num_of_bbox_in_frame_i,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       mem_rd_en_o,
  output logic [AddrW-1:0]           mem_rd_addr_o,
  input  logic [BboxW-1:0]           mem_rd_data_i,
  output logic [PeNum*BboxW-1:0]     set_of_bboxes_o,
  output logic                       new_set_from_dma_o,
  output logic                       new_frame_o,
  input  logic                       ready_new_set_i,
  input  logic                       ready_new_frame_i,
  input  logic                       valid_id_i,
  input  logic [MaxBboxes*IdLen-1:0] ids_in_i,
  output logic [MaxBboxes*IdLen-1:0] ids_out_o
);

  localparam int unsigned SlotW = $clog2(PeNum + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StFetch,
    StWaitSet,
    StWaitId
  } state_e;

  state_e                     state_q;
  logic [CntW-1:0]            n_q;
  logic [CntW-1:0]            rd_ptr_q;
  logic [SlotW-1:0]           cnt_q;
  logic [PeNum*BboxW-1:0]     set_q;
  logic [MaxBboxes*IdLen-1:0] ids_q;
  logic                       frame_done_q;
  logic                       new_set_q;
  logic                       new_frame_q;

  logic [CntW-1:0]  n_clamped;
  logic [CntW-1:0]  remain;
  logic [SlotW-1:0] k;
  logic [SlotW-1:0] wslot;
  logic             fetch_issue;

  always_comb begin
    n_clamped = (num_of_bbox_in_frame_i > CntW'(MaxBboxes)) ? CntW'(MaxBboxes)
                                                            : num_of_bbox_in_frame_i;
    remain    = n_q - rd_ptr_q;
    k         = (remain > CntW'(PeNum)) ? SlotW'(PeNum) : SlotW'(remain);
    // Read data lands one cycle after its strobe, so slot index trails the issue counter by one.
    wslot       = cnt_q - SlotW'(1);
    fetch_issue = (state_q == StFetch) && (cnt_q < k);
  end

  assign busy_o             = (state_q != StIdle);
  assign mem_rd_en_o        = fetch_issue;
  assign mem_rd_addr_o      = fetch_issue ? (AddrW'(rd_ptr_q) + AddrW'(cnt_q)) : '0;
  assign frame_done_o       = frame_done_q;
  assign new_set_from_dma_o = new_set_q;
  assign new_frame_o        = new_frame_q;
  assign set_of_bboxes_o    = set_q;
  assign ids_out_o          = ids_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      n_q          <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      set_q        <= '0;
      ids_q        <= '0;
      frame_done_q <= 1'b0;
      new_set_q    <= 1'b0;
      new_frame_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      new_set_q    <= 1'b0;
      new_frame_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_frame_i) begin
            n_q      <= n_clamped;
            rd_ptr_q <= '0;
            if (n_clamped == '0) begin
              frame_done_q <= 1'b1;
            end else begin
              state_q <= StWaitFrame;
            end
          end
        end
        StWaitFrame: begin
          if (ready_new_frame_i) begin
            new_frame_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          // First cycle blanks the bus so slots beyond k read as zero.
          if (cnt_q == '0) begin
            set_q <= '0;
          end else begin
            set_q[wslot*BboxW +: BboxW] <= mem_rd_data_i;
          end
          if (cnt_q == k) begin
            rd_ptr_q <= rd_ptr_q + CntW'(k);
            state_q  <= StWaitSet;
          end else begin
            cnt_q <= cnt_q + SlotW'(1);
          end
        end
        StWaitSet: begin
          if (ready_new_set_i) begin
            new_set_q <= 1'b1;
            if (rd_ptr_q < n_q) begin
              cnt_q   <= '0;
              state_q <= StFetch;
            end else begin
              state_q <= StWaitId;
            end
          end
        end
        StWaitId: begin
          if (valid_id_i) begin
            ids_q        <= ids_in_i;
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
